// File: rtl/sort_out_serializer.sv
// Output stage of the four-element sort pipeline: buffers sorted groups in a
// small FIFO and streams their elements out one per val/rdy transfer.
module sort_out_serializer #(
    parameter int unsigned p_nbits = 8,
    parameter int unsigned p_depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_val,
    input  logic [p_nbits-1:0]         in0,
    input  logic [p_nbits-1:0]         in1,
    input  logic [p_nbits-1:0]         in2,
    input  logic [p_nbits-1:0]         in3,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [p_nbits-1:0]         out_msg,
    output logic [1:0]                 out_idx,
    output logic                       out_last,
    output logic [$clog2(p_depth):0]   count,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(p_depth);
    localparam int unsigned CW = AW + 1;

    logic [p_nbits-1:0] r_mem [p_depth][4];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_idx;
    logic               r_overflow;

    logic w_val;
    logic w_xfer;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    always_comb begin
        w_val  = (r_count != '0);
        w_xfer = w_val && out_rdy;
        w_pop  = w_xfer && (r_idx == 2'd3);
        w_full = (r_count == CW'(p_depth));
        // A final-element pop frees the head slot in time for a same-cycle write.
        w_push = in_val && (!w_full || w_pop);
        w_drop = in_val && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_push && reset) begin
            r_mem[r_wptr][0] <= in0;
            r_mem[r_wptr][1] <= in1;
            r_mem[r_wptr][2] <= in2;
            r_mem[r_wptr][3] <= in3;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_idx      <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_xfer) begin
                r_idx <= r_idx + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        out_val  = w_val;
        out_msg  = w_val ? r_mem[r_rptr][r_idx] : '0;
        out_idx  = r_idx;
        out_last = (r_idx == 2'd3);
        count    = r_count;
        overflow = r_overflow;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(in_val));
            assert (!$isunknown(out_val));
            assert (!$isunknown(out_rdy));
        end
    end
`endif

endmodule

// File: tb/tb_sort_out_serializer.sv
// Bench for sort_out_serializer: fixed vector table for the single-group and
// backpressure cases, plus a scoreboard of expected elements for the rest.
module tb_sort_out_serializer;

    localparam int NB  = 8;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_val = 1'b0;
    logic [NB-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] out_msg;
    logic [1:0]    out_idx;
    logic          out_last;
    logic [2:0]    count;
    logic          overflow;

    sort_out_serializer #(.p_nbits(NB), .p_depth(DEP)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .out_idx  (out_idx),
        .out_last (out_last),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] msg;
        logic [1:0] idx;
    } elem_t;

    typedef struct {
        logic       v;
        logic [7:0] d0, d1, d2, d3;
        logic       rdy;
        logic       ev;
        logic [7:0] emsg;
        logic [1:0] eidx;
        logic       elast;
        logic [2:0] ecnt;
    } vec_t;

    elem_t sb[$];
    int    m_count;
    logic  m_ovf;
    int    checks = 0;
    int    failures = 0;
    vec_t  vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drives inputs, checks outputs against the model,
    // advances the model by one posedge, returns at the next negedge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input logic rdy);
        elem_t e;
        logic  pop_final;
        in_val  = v;
        in0     = a;
        in1     = b;
        in2     = c;
        in3     = d;
        out_rdy = rdy;
        chk("count", 32'(count), 32'(m_count));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("out_val", 32'(out_val), 32'(sb.size() != 0));
        pop_final = 1'b0;
        if (sb.size() != 0) begin
            e = sb[0];
            chk("out_msg", 32'(out_msg), 32'(e.msg));
            chk("out_idx", 32'(out_idx), 32'(e.idx));
            chk("out_last", 32'(out_last), 32'(e.idx == 2'd3));
            pop_final = rdy && (e.idx == 2'd3);
            if (rdy) void'(sb.pop_front());
        end else begin
            chk("out_msg_masked", 32'(out_msg), 32'd0);
            chk("out_idx_idle", 32'(out_idx), 32'd0);
        end
        if (v) begin
            if (m_count < DEP || pop_final) begin
                sb.push_back('{msg: a, idx: 2'd0});
                sb.push_back('{msg: b, idx: 2'd1});
                sb.push_back('{msg: c, idx: 2'd2});
                sb.push_back('{msg: d, idx: 2'd3});
                m_count++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop_final) m_count--;
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic reset_dut(input int n);
        reset   = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            step(1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h03, 8'h05, 8'h0a, 8'h0f, 1'b1, 1'b1, 8'h03, 2'd0, 1'b0, 3'd1};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 2'd1, 1'b0, 3'd1};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0a, 2'd2, 1'b0, 3'd1};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0f, 2'd3, 1'b1, 3'd1};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0};
        vecs[5]  = '{1'b1, 8'h03, 8'h05, 8'h0a, 8'h0f, 1'b0, 1'b1, 8'h03, 2'd0, 1'b0, 3'd1};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h03, 2'd0, 1'b0, 3'd1};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h03, 2'd0, 1'b0, 3'd1};
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h03, 2'd0, 1'b0, 3'd1};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 2'd1, 1'b0, 3'd1};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0a, 2'd2, 1'b0, 3'd1};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0f, 2'd3, 1'b1, 3'd1};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0};

        @(negedge clk);
        reset_dut(2);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_out_msg", 32'(out_msg), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Single group, then the same group under backpressure.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].rdy);
            chk($sformatf("vec%0d_val", i), 32'(out_val), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_msg", i), 32'(out_msg), 32'(vecs[i].emsg));
            chk($sformatf("vec%0d_idx", i), 32'(out_idx), 32'(vecs[i].eidx));
            chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].elast));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
        end

        // Fill past capacity with the sink stalled.
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 8'(k * 16), 8'(k * 16 + 1), 8'(k * 16 + 2), 8'(k * 16 + 3), 1'b0);
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_overflow", 32'(overflow), 32'd1);
        drain();
        chk("drain_overflow_sticky", 32'(overflow), 32'd1);
        chk("drain_count", 32'(count), 32'd0);

        // Reset in the middle of a group, with overflow still set.
        step(1'b1, 8'h21, 8'h22, 8'h23, 8'h24, 1'b0);
        step(1'b1, 8'h31, 8'h32, 8'h33, 8'h34, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("mid_idx_before_rst", 32'(out_idx), 32'd2);
        reset_dut(1);
        chk("mid_rst_out_val", 32'(out_val), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        step(1'b1, 8'h41, 8'h42, 8'h43, 8'h44, 1'b0);
        chk("post_rst_idx", 32'(out_idx), 32'd0);
        chk("post_rst_msg", 32'(out_msg), 32'h41);
        drain();

        // Full FIFO with a final-element pop in the same cycle as an enqueue.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'(8'h50 + k * 4), 8'(8'h51 + k * 4), 8'(8'h52 + k * 4),
                 8'(8'h53 + k * 4), 1'b0);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("full_head_idx", 32'(out_idx), 32'd3);
        chk("full_count", 32'(count), 32'd4);
        step(1'b1, 8'hc0, 8'hc1, 8'hc2, 8'hc3, 1'b1);
        chk("full_pop_count", 32'(count), 32'd4);
        chk("full_pop_overflow", 32'(overflow), 32'd0);
        drain();

        // Back-to-back streaming at one group per four cycles.
        for (int g = 0; g < 6; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) step(1'b1, 8'(g * 8 + 1), 8'(g * 8 + 2), 8'(g * 8 + 3),
                                 8'(g * 8 + 4), 1'b1);
                else step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
                chk("b2b_val", 32'(out_val), 32'd1);
                chk("b2b_count", 32'(count), 32'd1);
            end
        end
        drain();
        chk("end_count", 32'(count), 32'd0);
        chk("end_overflow", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/sort_out_serializer.md
Name: sort_out_serializer

Overview:
- Consumer end of the four-element sorting pipeline.
- Captures each sorted group ({out0..out3} plus out_val) from the sort unit into a small group FIFO. Re-emits the elements one per transfer on a val/rdy stream, ascending order (element 0 first).
- Needed because the sort pipeline has no backpressure: this block absorbs bursts and reports any group it cannot store.

Parameters:
- p_nbits, 8, width of one element.
- p_depth, 4, group FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  reset: synchronous, active-low.
- in_val  input  1  sorted group valid (from sort unit out_val).
- in0  input  p_nbits  smallest element.
- in1  input  p_nbits  second element.
- in2  input  p_nbits  third element.
- in3  input  p_nbits  largest element.
- out_val  output  1  stream element valid.
- out_rdy  input  1  downstream ready.
- out_msg  output  p_nbits  current element.
- out_idx  output  2  index of current element within its group (0..3).
- out_last  output  1  high when out_idx == 3.
- count  output  $clog2(p_depth)+1  groups currently stored, including the partially sent head group.
- overflow  output  1  sticky: a group was dropped.

Behaviour:
- Clock and reset: clk; reset reset, synchronous, active-low.
- When reset is low at a posedge:
  - write pointer, read pointer, count and element index are cleared to 0;
  - overflow is cleared to 0;
  - FIFO contents are don't-care.
- Reset asserted mid-operation discards all stored groups and any partially sent group. No in_val is sampled on a reset cycle.
- Outputs during and after reset:
  - out_val = 0;
  - out_msg = 0 (out_msg is masked with out_val: zero whenever out_val = 0);
  - out_idx = 0, out_last = 0, count = 0, overflow = 0.
- Enqueue: in_val is sampled at posedge; there is no ready toward the sort unit.
  - If the FIFO is not full, {in0,in1,in2,in3} is written at the write pointer, the write pointer increments, and count increments.
  - If the FIFO is full and the head group's final element is not transferring that cycle, the group is dropped and overflow is set to 1. overflow holds until reset.
  - Full FIFO with a simultaneous final-element transfer (out_val && out_rdy && out_idx == 3): the pop frees the slot, so the enqueue is accepted, no overflow, count unchanged.
- Enqueue-to-output latency: a group sampled at posedge t on an empty FIFO gives out_val = 1 with out_idx = 0 in the cycle after t. There is no combinational path from in_* to out_*.
- Dequeue and serialization:
  - out_val = (count != 0).
  - out_msg = head group element[out_idx], masked as above.
  - A transfer occurs when out_val && out_rdy.
  - On transfer with out_idx < 3: out_idx increments.
  - On transfer with out_idx == 3: out_idx wraps to 0, the read pointer increments, and count decrements.
- Stability: while out_val && !out_rdy, out_msg, out_idx and out_last hold stable. An enqueue into a non-head slot never disturbs them.
- Simultaneous enqueue and pop on a non-full FIFO: count unchanged, both pointers advance.
- Pointers wrap modulo p_depth. count saturates at p_depth by construction and never exceeds it.
- Order: groups leave in arrival order (FIFO). Elements within a group leave as in0, in1, in2, in3. Values are passed through unmodified; the block performs no re-sorting or checking.
- Throughput: one element per cycle with out_rdy held high, i.e. one group per 4 cycles. Sustained in_val faster than 1 in 4 cycles eventually overflows.
- Simulation-only assertions (excluded under SYNTHESIS): in_val, out_val and out_rdy are never X when reset is high.

Test Plan:
- Single group: reset low 2 cycles, then in_val = 1 with {03,05,0a,0f}, out_rdy = 1 -> next cycle out_msg = 03, idx 0. Then 05, 0a, and finally 0f with out_last = 1. out_val = 0 on the following cycle; count goes 1 -> 0.
- Backpressure: same group with out_rdy = 0 for 3 cycles, then 1 -> out_msg holds 03 with out_val = 1 for 3 cycles, then the sequence completes unchanged.
- Fill/overflow (p_depth = 4): out_rdy = 0, five consecutive in_val groups -> count = 4 and overflow = 1 after the fifth. Draining with out_rdy = 1 yields exactly the first four groups in order; overflow remains 1.
- Full with simultaneous pop: FIFO full, head at idx 3, out_rdy = 1 and in_val = 1 in the same cycle -> new group accepted, count stays 4, overflow stays 0. The new group appears last in the drain.
- Back-to-back streaming: in_val every 4th cycle, out_rdy = 1 -> continuous out_val = 1, count toggles between 0 and 1 only, no gaps after the first element.
- Reset mid-stream: 2 groups stored, head at idx 2, reset low 1 cycle -> out_val = 0, count = 0, idx = 0, overflow = 0. A subsequent group is emitted starting at idx 0.
